led_div_ctrl: RTL and testbench
===============================

LED_DIV_CTRL -- requirements
Module: led_div_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 24, width of the divide-ratio field and prescaler counter.
REQ-002 SHALL have port CLK  input  1  single system clock, all state on its rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port CFG_VALID  input  1  config request.
REQ-005 SHALL have port CFG_READY  output  1  config can be accepted.
REQ-006 SHALL have port CFG_DIV  input  PRESCALE_W  tick period minus one, in CLK cycles.
REQ-007 SHALL have port CFG_MODE  input  2  LED pattern mode.
REQ-008 SHALL have port START  input  1  start request, level-sampled.
REQ-009 SHALL have port STOP  input  1  stop request, level-sampled.
REQ-010 SHALL have port BUSY  output  1  high in ARM or RUN.
REQ-011 SHALL have port TICK  output  1  one-cycle pulse per prescaler expiry.
REQ-012 SHALL have port LED  output  4  pattern output, registered.

Function
REQ-013 SHALL implement FSM states IDLE, ARM, RUN.
REQ-014 SHALL drive CFG_READY=1 only in IDLE; CFG_VALID&&CFG_READY latches CFG_DIV into div_q and CFG_MODE into mode_q at that edge.
REQ-015 SHALL ignore CFG_VALID outside IDLE; div_q and mode_q hold.
REQ-016 SHALL move IDLE->ARM on START=1 with STOP=0; START and a config handshake in the same cycle: config latched and ARM entered, ARM uses the new values.
REQ-017 SHALL, in ARM, load prescaler with div_q and go to RUN next edge unconditionally, unless STOP=1 (then IDLE).
REQ-018 SHALL, in RUN, decrement prescaler each cycle; when prescaler==0 assert TICK that cycle and reload div_q at the edge.
REQ-019 SHALL update LED at the edge ending each TICK cycle; tick period exactly div_q+1 cycles; div_q=0 gives TICK every RUN cycle.
REQ-020 SHALL leave RUN for IDLE at the edge where STOP=1; STOP has priority over a coincident TICK's LED update (LED not advanced); START in RUN ignored.
REQ-021 SHALL hold LED in IDLE and ARM; TICK=0 outside RUN.
REQ-022 SHALL apply mode 0: binary up-count, 1111 wraps to 0000.
REQ-023 SHALL apply mode 1: rotate left, 1000->0001; a non-one-hot LED becomes 0001 on the next update.
REQ-024 SHALL apply mode 2: LED <= ~LED (0000<->1111; other values invert bitwise).
REQ-025 SHALL apply mode 3 per REQ-030.

Reset
REQ-026 SHALL, on RST_N=0, asynchronously force state IDLE, LED=0000, TICK=0, BUSY=0, CFG_READY=1 (once state IDLE), prescaler=0, div_q=0, mode_q=0.
REQ-027 SHALL, on reset mid-RUN, abandon the tick in progress; no TICK pulse on reset release.
REQ-028 SHALL accept config in the first cycle after RST_N deasserts.

Configuration
REQ-029 SHALL compile Gray-code mode only when macro LED_DIV_CTRL_GRAY_EN is defined.
REQ-030 SHALL, with LED_DIV_CTRL_GRAY_EN, make mode 3 a 4-bit Gray up-count (0000,0001,0011,0010,...,1000, wrap to 0000, arbitrary start value advanced by binary-to-Gray of Gray-to-binary+1); without it, mode 3 behaves exactly as mode 0.

Structure
REQ-031 SHALL place state enum (IDLE/ARM/RUN), mode encodings (MODE_BIN=0, MODE_ROT=1, MODE_TOG=2, MODE_GRAY=3) and LED_W=4 in package led_div_pkg.
REQ-032 SHALL implement the reloadable down-counter as sub-module led_prescaler (ports CLK, RST_N, load, load_val, en, expire).

Verification
REQ-033 SHALL cover: reset, cfg DIV=3 MODE=0, START one cycle -> ARM 1 cycle, TICK on 4th RUN cycle then every 4 cycles, LED 0000,0001,0010,...,1111,0000.
REQ-034 SHALL cover: DIV=0 MODE=1, LED preset non-one-hot via mode 0 (0011) -> first update 0001, then 0010,0100,1000,0001 each cycle.
REQ-035 SHALL cover: CFG_VALID in RUN with DIV=9 -> CFG_READY=0, period stays old value; after STOP, handshake completes in IDLE.
REQ-036 SHALL cover: STOP coincident with TICK -> IDLE next edge, LED unchanged, BUSY=0; START+STOP together in IDLE -> stays IDLE.
REQ-037 SHALL cover: RST_N low mid-RUN (LED=0101) -> LED=0000, BUSY=0 immediately, no TICK after release.
REQ-038 SHALL cover: mode 3, DIV=0, built with and without LED_DIV_CTRL_GRAY_EN -> 0001,0011,0010,0110 vs 0001,0010,0011,0100.

Source files
------------

// File: rtl/led_div_pkg.sv
// led_div_pkg: shared FSM states, LED mode encodings and the LED pattern step function.
// Gray-code mode 3 is compiled only when LED_DIV_CTRL_GRAY_EN is defined.
package led_div_pkg;
    localparam int LED_W = 4;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_ROT  = 2'd1;
    localparam logic [1:0] MODE_TOG  = 2'd2;
    localparam logic [1:0] MODE_GRAY = 2'd3;

    function automatic logic [LED_W-1:0] next_led(input logic [1:0] mode, input logic [LED_W-1:0] led);
`ifdef LED_DIV_CTRL_GRAY_EN
        logic [LED_W-1:0] b;
        b = (led ^ (led >> 1) ^ (led >> 2) ^ (led >> 3)) + 1'b1;
`endif
        case (mode)
            // anything that is not exactly one-hot restarts the rotation at bit 0
            MODE_ROT: return (led != '0 && (led & (led - 1'b1)) == '0) ? {led[LED_W-2:0], led[LED_W-1]} : LED_W'(1);
            MODE_TOG: return ~led;
`ifdef LED_DIV_CTRL_GRAY_EN
            MODE_GRAY: return b ^ (b >> 1);
`endif
            default: return led + 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: reloadable down-counter; expire pulses while enabled at zero and reloads.
module led_prescaler #(
    parameter int W = 24
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);
    logic [W-1:0] cnt;

    assign expire = en && cnt == '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (load || expire)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/led_div_ctrl.sv
// led_div_ctrl: configurable tick divider driving a 4-bit LED pattern through IDLE/ARM/RUN.
// Define LED_DIV_CTRL_GRAY_EN to make mode 3 a Gray up-count (otherwise it is a binary count).
module led_div_ctrl
    import led_div_pkg::*;
#(
    parameter int PRESCALE_W = 24
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CFG_VALID,
    output logic                  CFG_READY,
    input  logic [PRESCALE_W-1:0] CFG_DIV,
    input  logic [1:0]            CFG_MODE,
    input  logic                  START,
    input  logic                  STOP,
    output logic                  BUSY,
    output logic                  TICK,
    output logic [LED_W-1:0]      LED
);
    state_t                state, state_n;
    logic [PRESCALE_W-1:0] div_q;
    logic [1:0]            mode_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state == IDLE ? ((START && !STOP) ? ARM : IDLE) : (STOP ? IDLE : RUN);
        CFG_READY = state == IDLE;
        BUSY      = state != IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            mode_q <= MODE_BIN;
        end else if (CFG_VALID && CFG_READY) begin
            div_q  <= CFG_DIV;
            mode_q <= CFG_MODE;
        end
    end

    // STOP wins over a coincident tick: the LED keeps its value
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            LED <= '0;
        else if (TICK && !STOP)
            LED <= next_led(mode_q, LED);
    end

    led_prescaler #(.W(PRESCALE_W)) u_prescaler (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (state == ARM),
        .load_val (div_q),
        .en       (state == RUN),
        .expire   (TICK)
    );
endmodule

// File: tb/tb_led_div_ctrl.sv
// tb_led_div_ctrl: scoreboard bench; stimulus queues the LED value and spacing expected at each TICK.
module tb_led_div_ctrl;
    logic        clk = 1'b0;
    logic        RST_N = 1'b1;
    logic        CFG_VALID = 1'b0;
    logic        CFG_READY;
    logic [23:0] CFG_DIV = '0;
    logic [1:0]  CFG_MODE = '0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        BUSY;
    logic        TICK;
    logic [3:0]  LED;

    typedef struct {
        logic [3:0] led;
        int         gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    int   mark = 0;

    led_div_ctrl dut (
        .CLK       (clk),
        .RST_N     (RST_N),
        .CFG_VALID (CFG_VALID),
        .CFG_READY (CFG_READY),
        .CFG_DIV   (CFG_DIV),
        .CFG_MODE  (CFG_MODE),
        .START     (START),
        .STOP      (STOP),
        .BUSY      (BUSY),
        .TICK      (TICK),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    // monitor: every TICK must match the next queued LED value and spacing in cycles
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (TICK) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick at cycle %0d led %b", cyc_n, LED);
            end else begin
                e = q.pop_front();
                if (LED !== e.led) begin
                    errors++;
                    $display("FAIL tick_led actual %b expected %b", LED, e.led);
                end
                checks++;
                if (cyc_n - mark != e.gap) begin
                    errors++;
                    $display("FAIL tick_gap actual %0d expected %0d", cyc_n - mark, e.gap);
                end
            end
            mark = cyc_n;
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] l, input int g);
        q.push_back('{l, g});
    endtask

    task automatic go(input bit cfg, input logic [23:0] div, input logic [1:0] mode);
        CFG_VALID = cfg;
        CFG_DIV   = div;
        CFG_MODE  = mode;
        START     = 1'b1;
        chk("idle_ready", CFG_READY, 1);
        step;
        CFG_VALID = 1'b0;
        START     = 1'b0;
        mark      = cyc_n;
        chk("arm_busy", BUSY, 1);
        chk("arm_ready", CFG_READY, 0);
    endtask

    task automatic stop_run;
        STOP = 1'b1;
        step;
        STOP = 1'b0;
        chk("stop_busy", BUSY, 0);
        chk("stop_tick", TICK, 0);
    endtask

    task automatic wait_q(input int left);
        int n = 0;
        while (q.size() > left && n < 200) begin
            step;
            n++;
        end
        if (q.size() > left) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual %0d pending expected %0d", q.size(), left);
            q.delete();
        end
    endtask

    initial begin
        #1 RST_N = 1'b0;
        step;
        step;
        chk("rst_led", LED, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_ready", CFG_READY, 1);
        chk("rst_tick", TICK, 0);

        // config + START in the first cycle after release, DIV=3 binary count
        RST_N = 1'b1;
        go(1, 24'd3, 2'd0);
        for (int i = 0; i < 17; i++) push(4'(i), i == 0 ? 5 : 4);
        wait_q(0);
        stop_run;
        chk("bin_led_after", LED, 4'b0001);

        // preset 0011 in binary mode, stop coincident with the tick holds LED
        go(1, 24'd0, 2'd0);
        push(4'b0001, 2); push(4'b0010, 1); push(4'b0011, 1);
        wait_q(1);
        stop_run;
        chk("stop_tick_led", LED, 4'b0011);

        // rotate from non-one-hot
        go(1, 24'd0, 2'd1);
        push(4'b0011, 2); push(4'b0001, 1); push(4'b0010, 1);
        push(4'b0100, 1); push(4'b1000, 1); push(4'b0001, 1);
        wait_q(1);
        stop_run;
        chk("rot_led", LED, 4'b0001);

        // config request while running is refused; completes once back in IDLE
        go(1, 24'd2, 2'd0);
        CFG_VALID = 1'b1;
        CFG_DIV   = 24'd9;
        CFG_MODE  = 2'd2;
        push(4'b0001, 4); push(4'b0010, 3); push(4'b0011, 3);
        wait_q(0);
        chk("run_ready", CFG_READY, 0);
        stop_run;
        chk("late_cfg_led", LED, 4'b0100);
        chk("late_cfg_ready", CFG_READY, 1);
        step;
        CFG_VALID = 1'b0;
        go(0, 24'd0, 2'd0);
        push(4'b0100, 11); push(4'b1011, 10);
        wait_q(0);
        stop_run;
        chk("tog_led", LED, 4'b0100);

        // START with STOP in IDLE stays idle
        START = 1'b1;
        STOP  = 1'b1;
        step;
        chk("start_stop_busy", BUSY, 0);
        step;
        chk("start_stop_busy2", BUSY, 0);
        START = 1'b0;
        STOP  = 1'b0;

        // reach 0101, then reset mid-RUN
        go(1, 24'd0, 2'd0);
        push(4'b0100, 2); push(4'b0101, 1);
        wait_q(1);
        stop_run;
        chk("pre_rst_led", LED, 4'b0101);
        go(1, 24'd3, 2'd0);
        step;
        chk("pre_rst_busy", BUSY, 1);
        RST_N = 1'b0;
        #1;
        chk("mid_rst_led", LED, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_tick", TICK, 0);
        chk("mid_rst_ready", CFG_READY, 1);
        step;
        step;
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step;
            chk("post_rst_tick", TICK, 0);
        end

        // cleared div_q/mode_q: run without config gives div 0 binary
        go(0, 24'd7, 2'd2);
        push(4'b0000, 2); push(4'b0001, 1);
        wait_q(1);
        stop_run;
        chk("rst_cfg_led", LED, 4'b0001);

        // mode 3 from 0001
        go(1, 24'd0, 2'd3);
`ifdef LED_DIV_CTRL_GRAY_EN
        push(4'b0001, 2); push(4'b0011, 1); push(4'b0010, 1); push(4'b0110, 1);
        wait_q(1);
        stop_run;
        chk("mode3_led", LED, 4'b0110);
`else
        push(4'b0001, 2); push(4'b0010, 1); push(4'b0011, 1); push(4'b0100, 1);
        wait_q(1);
        stop_run;
        chk("mode3_led", LED, 4'b0100);
`endif

        step;
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end
endmodule
